// File: rtl/dump_pkg.sv
// rtl/dump_pkg.sv - shared types and default sizes for the register-file dump controller
package dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_CYC_W    = 16;

endpackage

// File: rtl/dump_out_stage.sv
// rtl/dump_out_stage.sv - single-entry valid/ready output register for dump beats
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             drop any held beat (start of a new scan)
//   load_i              capture load_idx_i/load_data_i as a new beat
//   load_idx_i/_data_i  beat contents to capture
//   ready_i             consumer accepts the current beat
//   valid_o/idx_o/data_o  current beat
module dump_out_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_idx_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;

    // The owner only asserts load_i when the slot is empty or being drained,
    // so a load never overwrites an unaccepted beat.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            idx_d   = '0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            idx_d   = load_idx_i;
            data_d  = load_data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign data_o  = data_q;

endmodule

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - cycle-triggered register-file dump controller with valid/ready output
//
// Counts core cycles while run_i is high, halts the core at end_cycle_i or on
// dump_req_i, then streams every register-file entry out one beat per cycle.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   run_i                      core running, enables counting
//   end_cycle_i                cycle count that triggers the dump
//   dump_req_i                 manual dump trigger
//   rf_raddr_o / rf_rdata_i    register-file read port (combinational data)
//   dump_valid_o/ready_i/idx_o/data_o  output beat stream
//   cycle_cnt_o                cycles counted
//   halt_o, busy_o, done_o     status
//
// Build option: DUMP_SKIP_ZERO_EN suppresses beats for registers reading zero.
module regfile_dump_ctrl
    import dump_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CYC_W    = DEF_CYC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic [CYC_W-1:0]  end_cycle_i,
    input  logic              dump_req_i,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic [CYC_W-1:0]  cycle_cnt_o,
    output logic              halt_o,
    output logic              busy_o,
    output logic              done_o
);

    // Scan index is one bit wider than the address so it can hold NUM_REGS
    // (the "scan finished" value) even when NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] SCAN_END = (ADDR_W + 1)'(NUM_REGS);

    dump_state_e       state_q, state_d;
    logic [CYC_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [ADDR_W:0]   scan_idx_q, scan_idx_d;

    logic out_valid;
    logic slot_free;
    logic scan_left;
    logic scan_step;
    logic out_load;
    logic enter_dump;

    assign slot_free = !out_valid || dump_ready_i;
    assign scan_left = scan_idx_q < SCAN_END;
    assign scan_step = (state_q == ST_DUMP) && slot_free && scan_left;

`ifdef DUMP_SKIP_ZERO_EN
    // Zero registers still use up their scan cycle but never reach the output.
    assign out_load = scan_step && (rf_rdata_i != '0);
`else
    assign out_load = scan_step;
`endif

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        scan_idx_d  = scan_idx_q;
        enter_dump  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dump_req_i) begin
                    enter_dump = 1'b1;
                end else if (run_i) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (dump_req_i || (cycle_cnt_q == end_cycle_i)) begin
                    enter_dump = 1'b1;
                end else if (run_i && (cycle_cnt_q != '1)) begin
                    cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
                end
            end
            ST_DUMP: begin
                if (scan_step) begin
                    scan_idx_d = scan_idx_q + (ADDR_W + 1)'(1);
                end
                // Finished once the scan is exhausted and the last beat (if any)
                // is leaving the output register this cycle.
                if (!scan_left && slot_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (dump_req_i) begin
                    enter_dump = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (enter_dump) begin
            state_d    = ST_DUMP;
            scan_idx_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cycle_cnt_q <= '0;
            scan_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            scan_idx_q  <= scan_idx_d;
        end
    end

    dump_out_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_out_stage (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (enter_dump),
        .load_i      (out_load),
        .load_idx_i  (scan_idx_q[ADDR_W-1:0]),
        .load_data_i (rf_rdata_i),
        .ready_i     (dump_ready_i),
        .valid_o     (out_valid),
        .idx_o       (dump_idx_o),
        .data_o      (dump_data_o)
    );

    assign dump_valid_o = out_valid;
    assign rf_raddr_o   = scan_idx_q[ADDR_W-1:0];
    assign cycle_cnt_o  = cycle_cnt_q;
    assign halt_o       = (state_q == ST_DUMP);
    assign busy_o       = (state_q == ST_DUMP);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb/tb_regfile_dump_ctrl.sv - scoreboard testbench for regfile_dump_ctrl
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] end_cycle = 16'd100;
    logic        dump_req = 1'b0;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic [15:0] cycle_cnt;
    logic        halt, busy, done;

    logic        run4 = 1'b0;
    logic [3:0]  end4 = 4'd15;
    logic        req4 = 1'b0;
    logic [4:0]  raddr4;
    logic [31:0] rdata4;
    logic        valid4;
    logic        ready4 = 1'b1;
    logic [4:0]  idx4;
    logic [31:0] data4;
    logic [3:0]  cnt4;
    logic        halt4, busy4, done4;

    logic [31:0] rf [32];

    assign rf_rdata = rf[rf_raddr];
    assign rdata4   = rf[raddr4];

    always #5 clk = ~clk;

    regfile_dump_ctrl u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .run_i        (run),
        .end_cycle_i  (end_cycle),
        .dump_req_i   (dump_req),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_i   (rf_rdata),
        .dump_valid_o (dump_valid),
        .dump_ready_i (dump_ready),
        .dump_idx_o   (dump_idx),
        .dump_data_o  (dump_data),
        .cycle_cnt_o  (cycle_cnt),
        .halt_o       (halt),
        .busy_o       (busy),
        .done_o       (done)
    );

    regfile_dump_ctrl #(.CYC_W(4)) u_dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .run_i        (run4),
        .end_cycle_i  (end4),
        .dump_req_i   (req4),
        .rf_raddr_o   (raddr4),
        .rf_rdata_i   (rdata4),
        .dump_valid_o (valid4),
        .dump_ready_i (ready4),
        .dump_idx_o   (idx4),
        .dump_data_o  (data4),
        .cycle_cnt_o  (cnt4),
        .halt_o       (halt4),
        .busy_o       (busy4),
        .done_o       (done4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected beats pushed when a dump is triggered.
    logic [4:0]  exp_idx [$];
    logic [31:0] exp_data [$];
    int          exp_total;
    int          beats = 0;
    int          beats_base = 0;

    task automatic push_dump();
        exp_total = 0;
        for (int i = 0; i < 32; i++) begin
`ifdef DUMP_SKIP_ZERO_EN
            if (rf[i] == 32'd0) continue;
`endif
            exp_idx.push_back(5'(i));
            exp_data.push_back(rf[i]);
            exp_total++;
        end
        beats_base = beats;
    endtask

    logic        prev_stall = 1'b0;
    logic [4:0]  prev_idx;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", 64'(dump_valid), 1);
                check("stall_idx", 64'(dump_idx), 64'(prev_idx));
                check("stall_data", 64'(dump_data), 64'(prev_data));
            end
            if (dump_valid && dump_ready) begin
                if (exp_idx.size() == 0) begin
                    check("unexpected_beat", 64'(dump_idx), 64'hFFFF);
                end else begin
                    check("beat_idx", 64'(dump_idx), 64'(exp_idx.pop_front()));
                    check("beat_data", 64'(dump_data), 64'(exp_data.pop_front()));
                end
                beats++;
            end
        end
        prev_stall = dump_valid && !dump_ready && !rst;
        prev_idx   = dump_idx;
        prev_data  = dump_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dump_req = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(dump_valid), 0);
        check("rst_idx", 64'(dump_idx), 0);
        check("rst_data", 64'(dump_data), 0);
        check("rst_cnt", 64'(cycle_cnt), 0);
        check("rst_raddr", 64'(rf_raddr), 0);
        check("rst_halt", 64'(halt), 0);
        check("rst_done", 64'(done), 0);
        exp_idx.delete();
        exp_data.delete();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        check("done_reached", 64'(done), 1);
    endtask

    task automatic check_dump_complete(input string tag);
        check({tag, "_beats"}, 64'(beats - beats_base), 64'(exp_total));
        check({tag, "_queue_empty"}, 64'(exp_idx.size()), 0);
        check({tag, "_halt_low"}, 64'(halt), 0);
        check({tag, "_busy_low"}, 64'(busy), 0);
    endtask

    int n;
    int cyc;
    int m_st;
    int m_cnt;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);

        // Run until the programmed end cycle.
        run = 1'b1;
        end_cycle = 16'd100;
        dump_ready = 1'b1;
        do_reset();
        push_dump();
        n = 0;
        while (!halt && n < 300) begin
            tick();
            n++;
        end
        check("t1_halt", 64'(halt), 1);
        check("t1_busy", 64'(busy), 1);
        check("t1_cnt", 64'(cycle_cnt), 100);
`ifndef DUMP_SKIP_ZERO_EN
        check("t1_first_empty", 64'(dump_valid), 0);
        tick();
        check("t1_first_valid", 64'(dump_valid), 1);
        check("t1_first_idx", 64'(dump_idx), 0);
        wait_done(100, cyc);
        check("t1_burst_len", 64'(cyc), 32);
`else
        wait_done(100, cyc);
`endif
        check_dump_complete("t1");
        check("t1_cnt_frozen", 64'(cycle_cnt), 100);
        tick();
        tick();
        tick();
        check("t1_done_holds", 64'(done), 1);

        // Backpressure 1,0,0,1.
        do_reset();
        push_dump();
        n = 0;
        while (!done && n < 600) begin
            dump_ready = ((n % 4) == 0) || ((n % 4) == 3);
            tick();
            n++;
        end
        dump_ready = 1'b1;
        check("t2_done", 64'(done), 1);
        check_dump_complete("t2");

        // Manual trigger at cycle 10, then a repeat dump from DONE.
        do_reset();
        n = 0;
        while (cycle_cnt != 16'd10 && n < 50) begin
            tick();
            n++;
        end
        check("t3_reach10", 64'(cycle_cnt), 10);
        push_dump();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t3_halt", 64'(halt), 1);
        check("t3_cnt", 64'(cycle_cnt), 10);
        wait_done(100, cyc);
        check_dump_complete("t3a");
        push_dump();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t3_redump_halt", 64'(halt), 1);
        wait_done(100, cyc);
        check_dump_complete("t3b");
        check("t3_cnt_kept", 64'(cycle_cnt), 10);

        // Reset mid-dump.
        end_cycle = 16'd20;
        do_reset();
        push_dump();
        n = 0;
        while ((beats - beats_base) < 6 && n < 100) begin
            tick();
            n++;
        end
        check("t4_six_beats", 64'((beats - beats_base) >= 6), 1);
        rst = 1'b1;
        tick();
        check("t4_valid", 64'(dump_valid), 0);
        check("t4_idx", 64'(dump_idx), 0);
        check("t4_data", 64'(dump_data), 0);
        check("t4_cnt", 64'(cycle_cnt), 0);
        check("t4_raddr", 64'(rf_raddr), 0);
        check("t4_halt", 64'(halt), 0);
        check("t4_busy", 64'(busy), 0);
        check("t4_done", 64'(done), 0);
        exp_idx.delete();
        exp_data.delete();
        rst = 1'b0;
        push_dump();
        wait_done(200, cyc);
        check_dump_complete("t4");

        // end_cycle 0 dumps on the second edge after reset release.
        end_cycle = 16'd0;
        do_reset();
        push_dump();
        tick();
        check("t5_edge1_halt", 64'(halt), 0);
        tick();
        check("t5_edge2_halt", 64'(halt), 1);
        wait_done(100, cyc);
        check_dump_complete("t5");
        check("t5_cnt", 64'(cycle_cnt), 0);

        // 4-bit counter with pauses, trigger at 15.
        run = 1'b0;
        do_reset();
        m_st = 0;
        m_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            run4 = (k % 3) != 2;
            if (m_st == 0) begin
                if (run4) m_st = 1;
            end else if (m_st == 1) begin
                if (m_cnt == 15) m_st = 2;
                else if (run4) m_cnt++;
            end
            tick();
            check("t6_cnt", 64'(cnt4), 64'(m_cnt));
            check("t6_stopped", 64'(halt4 | done4), 64'(m_st == 2));
        end
        run4 = 1'b1;
        n = 0;
        while (!done4 && n < 100) begin
            tick();
            n++;
        end
        check("t6_done", 64'(done4), 1);
        check("t6_no_wrap", 64'(cnt4), 15);
        check("t6_busy", 64'(busy4), 0);
        check("t6_last_idx", 64'(idx4), 31);
        check("t6_last_data", 64'(data4), 64'(rf[31]));
        check("t6_valid_low", 64'(valid4), 0);
        run4 = 1'b0;

        // Sparse register file, then all-zero file.
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[2]  = 32'h0000_00A5;
        rf[7]  = 32'h0000_1234;
        rf[31] = 32'hDEAD_BEEF;
        end_cycle = 16'd100;
        do_reset();
        push_dump();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t7_halt", 64'(halt), 1);
        wait_done(100, cyc);
        check_dump_complete("t7a");
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        push_dump();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        wait_done(100, cyc);
        check_dump_complete("t7b");
        check("t7_zero_latency", 64'(cyc), 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
